// File: rtl/sr_flag_pkg.sv
// Shared types and constants for the SR flag sequencer and its flag cells.
package sr_flag_pkg;

   // Sequencer FSM: ARB picks a winner, HOLD masks the winner's still-high req.
   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_HOLD = 1'b1
   } fsm_state_t;

   // Per-requester operation encoding on the op bus.
   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_flag_cell.sv
// One SR status flag cell with synchronous active-low reset and a bulk clear,
// plus a small checker that watches for the illegal s=r=1 input.
module sr_flag_cell_chk (
   input logic clk,
   input logic rst_n,
   input logic s,
   input logic r
);

   // s and r must never be asserted together on any sampled edge.
   property p_no_sr_both;
      @(posedge clk) disable iff (!rst_n) !(s && r);
   endproperty

   a_no_sr_both : assert property (p_no_sr_both)
      else $error("sr_flag_cell: s and r asserted together");

endmodule

module sr_flag_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic s,
   input  logic r,
   output logic q
);

   logic q_r;

   // Capture set/clear on the edge; reset and bulk clear both force zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_r <= 1'b0;
      end else if (clr) begin
         q_r <= 1'b0;
      end else begin
         case ({s, r})
            2'b10:   q_r <= 1'b1;
            2'b01:   q_r <= 1'b0;
            default: q_r <= q_r;
         endcase
      end
   end

   assign q = q_r;

   sr_flag_cell_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (s),
      .r     (r)
   );

endmodule

// File: rtl/sr_flag_sequencer.sv
// Round-robin sequencer sharing a bank of SR flag cells between requesters.
// One grant every two cycles; the granted op/idx becomes a one-hot s or r
// pulse that the addressed cell captures on the following edge.
module sr_flag_sequencer
   import sr_flag_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IDXW  = $clog2(NFLAG)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      op,
   input  logic [NREQ*IDXW-1:0] idx,
   input  logic                 clr_all,
   output logic [NREQ-1:0]      gnt,
   output logic [NFLAG-1:0]     flags,
   output logic                 err
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Returns {found, winner}: first requester at or after ptr_v, wrapping.
   function automatic logic [PTRW:0] rr_pick(input logic [NREQ-1:0] req_v,
                                             input logic [PTRW-1:0] ptr_v);
      logic [PTRW:0] res;
      int            cand;
      res = {(PTRW+1){1'b0}};
      // Scan from the farthest candidate down so the nearest one wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = (int'(ptr_v) + k) % NREQ;
         if (req_v[cand]) begin
            res = {1'b1, PTRW'(cand)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   fsm_state_t       state_r;
   logic [PTRW-1:0]  ptr_r;
   logic [NREQ-1:0]  gnt_r;
   logic [NFLAG-1:0] s_r;
   logic [NFLAG-1:0] r_r;
   logic             err_r;

   logic [PTRW:0]    pick_s;
   logic             win_found_s;
   logic [PTRW-1:0]  win_s;
   logic             win_op_s;
   logic [IDXW-1:0]  win_idx_s;
   logic             win_oor_s;
   logic [NREQ-1:0]  win_onehot_s;
   logic [PTRW-1:0]  ptr_next_s;
   logic [NFLAG-1:0] set_vec_s;
   logic [NFLAG-1:0] clr_vec_s;

   // Decode the round-robin winner and its one-hot s/r request vectors.
   always_comb begin
      pick_s       = rr_pick(req, ptr_r);
      win_found_s  = pick_s[PTRW];
      win_s        = pick_s[PTRW-1:0];
      win_op_s     = op[win_s];
      win_idx_s    = idx[win_s*IDXW +: IDXW];
      win_oor_s    = (int'(win_idx_s) >= NFLAG);
      win_onehot_s = {NREQ{1'b0}};
      win_onehot_s[win_s] = 1'b1;
      if (int'(win_s) == NREQ - 1) begin
         ptr_next_s = {PTRW{1'b0}};
      end else begin
         ptr_next_s = win_s + {{(PTRW-1){1'b0}}, 1'b1};
      end
      set_vec_s = {NFLAG{1'b0}};
      clr_vec_s = {NFLAG{1'b0}};
      // An out-of-range index matches no cell, so nothing is driven.
      for (int f = 0; f < NFLAG; f++) begin
         if (f == int'(win_idx_s)) begin
            set_vec_s[f] = (win_op_s == OP_SET);
            clr_vec_s[f] = (win_op_s == OP_CLR);
         end else begin
            set_vec_s[f] = 1'b0;
            clr_vec_s[f] = 1'b0;
         end
      end
   end

   // Arbitration FSM with registered grant, s/r vectors, pointer and error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_ARB;
         ptr_r   <= {PTRW{1'b0}};
         gnt_r   <= {NREQ{1'b0}};
         s_r     <= {NFLAG{1'b0}};
         r_r     <= {NFLAG{1'b0}};
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_ARB: begin
               if (win_found_s) begin
                  gnt_r   <= win_onehot_s;
                  s_r     <= set_vec_s;
                  r_r     <= clr_vec_s;
                  ptr_r   <= ptr_next_s;
                  err_r   <= err_r | win_oor_s;
                  state_r <= ST_HOLD;
               end else begin
                  gnt_r   <= {NREQ{1'b0}};
                  s_r     <= {NFLAG{1'b0}};
                  r_r     <= {NFLAG{1'b0}};
                  ptr_r   <= ptr_r;
                  err_r   <= err_r;
                  state_r <= ST_ARB;
               end
            end
            ST_HOLD: begin
               gnt_r   <= {NREQ{1'b0}};
               s_r     <= {NFLAG{1'b0}};
               r_r     <= {NFLAG{1'b0}};
               state_r <= ST_ARB;
            end
            default: begin
               gnt_r   <= {NREQ{1'b0}};
               s_r     <= {NFLAG{1'b0}};
               r_r     <= {NFLAG{1'b0}};
               state_r <= ST_ARB;
            end
         endcase
      end
   end

   assign gnt = gnt_r;
   assign err = err_r;

   for (genvar f = 0; f < NFLAG; f++) begin : g_cell
      sr_flag_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr_all),
         .s     (s_r[f]),
         .r     (r_r[f]),
         .q     (flags[f])
      );
   end

endmodule

// File: tb/tb_sr_flag_sequencer.sv
// Self-checking bench: an 8-flag and a 6-flag sequencer share one stimulus
// stream and are compared against a transaction-level reference model.
module tb_sr_flag_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr_all;
   logic [3:0]  req;
   logic [3:0]  op;
   logic [11:0] idx;
   logic [3:0]  gnt8, gnt6;
   logic [7:0]  flags8;
   logic [5:0]  flags6;
   logic        err8, err6;

   int checks = 0;
   int errors = 0;

   // Reference model state, index 0 = 8-flag DUT, index 1 = 6-flag DUT.
   logic [7:0] m_flags [2];
   int         m_ptr   [2];
   bit         m_err   [2];
   bit         m_hold  [2];
   bit         m_pv    [2];
   bit         m_pop   [2];
   int         m_pidx  [2];
   logic [3:0] m_gnt   [2];

   always #5 clk = ~clk;

   sr_flag_sequencer #(.NREQ(4), .NFLAG(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
      .clr_all(clr_all), .gnt(gnt8), .flags(flags8), .err(err8)
   );

   sr_flag_sequencer #(.NREQ(4), .NFLAG(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
      .clr_all(clr_all), .gnt(gnt6), .flags(flags6), .err(err6)
   );

   // Advance the model by one clock edge using the inputs sampled there.
   function automatic void model_edge();
      for (int d = 0; d < 2; d++) begin
         int nf;
         bit found;
         int w;
         nf = (d == 0) ? 8 : 6;
         if (!rst_n) begin
            m_flags[d] = 8'h00; m_ptr[d] = 0; m_err[d] = 1'b0;
            m_hold[d] = 1'b0; m_pv[d] = 1'b0; m_gnt[d] = 4'b0000;
         end else begin
            if (clr_all) m_flags[d] = 8'h00;
            else if (m_pv[d] && m_pidx[d] < nf) m_flags[d][m_pidx[d]] = m_pop[d];
            m_pv[d]  = 1'b0;
            m_gnt[d] = 4'b0000;
            if (m_hold[d]) begin
               m_hold[d] = 1'b0;
            end else begin
               found = 1'b0;
               for (int k = 0; k < 4; k++) begin
                  w = (m_ptr[d] + k) % 4;
                  if (!found && req[w]) begin
                     found     = 1'b1;
                     m_gnt[d]  = 4'(1 << w);
                     m_pv[d]   = 1'b1;
                     m_pop[d]  = op[w];
                     m_pidx[d] = int'(idx[w*3 +: 3]);
                     if (m_pidx[d] >= nf) m_err[d] = 1'b1;
                     m_ptr[d]  = (w + 1) % 4;
                     m_hold[d] = 1'b1;
                  end
               end
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_req(input int i, input bit o, input int ix);
      op[i]          = o;
      idx[i*3 +: 3]  = 3'(ix);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr_all = 1'b0; req = 4'b1111; op = 4'b1111; idx = 12'($urandom);
      tick(); tick();
      checks++; if (gnt8 !== 4'b0000 || gnt6 !== 4'b0000) begin errors++;
         $display("FAIL reset_gnt got %b/%b want 0000", gnt8, gnt6); end
      checks++; if (flags8 !== 8'h00 || flags6 !== 6'h00) begin errors++;
         $display("FAIL reset_flags got %h/%h want 00", flags8, flags6); end
      checks++; if (err8 !== 1'b0 || err6 !== 1'b0) begin errors++;
         $display("FAIL reset_err got %b/%b want 0", err8, err6); end
      rst_n = 1'b1; req = 4'b0000;
      tick();
      checks++; if (gnt8 !== 4'b0000 || gnt8 !== m_gnt[0]) begin errors++;
         $display("FAIL reset_release_gnt got %b want 0000", gnt8); end
   endtask

   task automatic test_single();
      set_req(0, 1'b1, 3); req = 4'b0001;
      tick();
      checks++; if (gnt8 !== 4'b0001) begin errors++;
         $display("FAIL single_gnt got %b want 0001", gnt8); end
      checks++; if (flags8 !== 8'h00) begin errors++;
         $display("FAIL single_flags_early got %h want 00", flags8); end
      req = 4'b0000;
      tick();
      checks++; if (flags8 !== 8'h08 || gnt8 !== 4'b0000) begin errors++;
         $display("FAIL single_set got flags %h gnt %b want 08/0000", flags8, gnt8); end
      set_req(0, 1'b0, 3); req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      checks++; if (flags8 !== 8'h00) begin errors++;
         $display("FAIL single_clear got %h want 00", flags8); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [9];
      int cnt [4];
      exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
      rst_n = 1'b0; req = 4'b0000;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, i);
      req = 4'b1111;
      for (int t = 0; t < 9; t++) begin
         tick();
         checks++; if (gnt8 !== exp_g[t] || gnt6 !== exp_g[t]) begin errors++;
            $display("FAIL rr_gnt[%0d] got %b/%b want %b", t, gnt8, gnt6, exp_g[t]); end
         if (t == 7) begin
            checks++; if (flags8 !== 8'h0F) begin errors++;
               $display("FAIL rr_flags got %h want 0f", flags8); end
         end
      end
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int t = 0; t < 16; t++) begin
         tick();
         for (int i = 0; i < 4; i++) if (gnt8[i]) cnt[i]++;
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (cnt[i] != 2) begin errors++;
            $display("FAIL rr_fair[%0d] got %0d want 2", i, cnt[i]); end
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_wrap();
      req = 4'b1000;
      tick();
      checks++; if (gnt8 !== 4'b1000) begin errors++;
         $display("FAIL wrap_first got %b want 1000", gnt8); end
      req = 4'b0000;
      tick();
      req = 4'b1001;
      tick();
      checks++; if (gnt8 !== 4'b0001) begin errors++;
         $display("FAIL wrap_to0 got %b want 0001", gnt8); end
      req = 4'b1000;
      tick();
      checks++; if (gnt8 !== 4'b0000) begin errors++;
         $display("FAIL wrap_hold got %b want 0000", gnt8); end
      tick();
      checks++; if (gnt8 !== 4'b1000) begin errors++;
         $display("FAIL wrap_to3 got %b want 1000", gnt8); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_clr_all();
      for (int f = 0; f < 8; f++) begin
         set_req(0, 1'b1, f); req = 4'b0001;
         tick();
         req = 4'b0000;
         tick();
      end
      checks++; if (flags8 !== 8'hFF) begin errors++;
         $display("FAIL clr_fill got %h want ff", flags8); end
      set_req(1, 1'b1, 5); req = 4'b0010;
      tick();
      req = 4'b0000; clr_all = 1'b1;
      tick();
      clr_all = 1'b0;
      checks++; if (flags8 !== 8'h00) begin errors++;
         $display("FAIL clr_collide got %h want 00", flags8); end
      set_req(1, 1'b1, 5); req = 4'b0010;
      tick();
      req = 4'b0000; clr_all = 1'b1;
      tick();
      clr_all = 1'b0;
      checks++; if (flags8 !== 8'h00) begin errors++;
         $display("FAIL clr_discard got %h want 00", flags8); end
      set_req(2, 1'b1, 6); req = 4'b0100; clr_all = 1'b1;
      tick();
      clr_all = 1'b0; req = 4'b0000;
      checks++; if (gnt8 !== 4'b0100 || flags8 !== 8'h00) begin errors++;
         $display("FAIL clr_grant got gnt %b flags %h want 0100/00", gnt8, flags8); end
      tick();
      checks++; if (flags8 !== 8'h40 || flags6 !== m_flags[1][5:0]) begin errors++;
         $display("FAIL clr_after got %h/%h want 40/%h", flags8, flags6, m_flags[1][5:0]); end
   endtask

   task automatic test_error();
      logic [5:0] before6;
      rst_n = 1'b0; req = 4'b0000;
      tick();
      rst_n = 1'b1;
      checks++; if (err6 !== 1'b0) begin errors++;
         $display("FAIL err_clean got %b want 0", err6); end
      set_req(0, 1'b1, 2); req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      before6 = flags6;
      set_req(0, 1'b1, 7); req = 4'b0001;
      tick();
      req = 4'b0000;
      checks++; if (gnt6 !== 4'b0001 || err6 !== 1'b1 || err8 !== 1'b0) begin errors++;
         $display("FAIL err_set got gnt %b err6 %b err8 %b want 0001/1/0", gnt6, err6, err8); end
      tick();
      checks++; if (flags6 !== before6 || flags6 !== 6'h04 || flags8 !== 8'h84) begin errors++;
         $display("FAIL err_flags got %h/%h want 04/84", flags6, flags8); end
      set_req(1, 1'b0, 2); req = 4'b0010;
      tick();
      req = 4'b0000;
      tick(); tick();
      checks++; if (err6 !== 1'b1 || flags6 !== 6'h00) begin errors++;
         $display("FAIL err_sticky got err %b flags %h want 1/00", err6, flags6); end
   endtask

   task automatic test_midop_reset();
      set_req(1, 1'b1, 4); req = 4'b0010;
      tick();
      rst_n = 1'b0; req = 4'b0000;
      tick();
      checks++; if (flags8 !== 8'h00 || gnt8 !== 4'b0000 || err6 !== 1'b0 || err8 !== 1'b0) begin
         errors++;
         $display("FAIL midop_reset got flags %h gnt %b err %b/%b want 00/0000/0/0",
                  flags8, gnt8, err8, err6); end
      rst_n = 1'b1; set_req(3, 1'b1, 1); req = 4'b1000;
      tick();
      checks++; if (gnt8 !== 4'b1000) begin errors++;
         $display("FAIL midop_arb got %b want 1000", gnt8); end
      req = 4'b0000;
      tick();
      checks++; if (flags8 !== 8'h02) begin errors++;
         $display("FAIL midop_flags got %h want 02", flags8); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 400; t++) begin
         rst_n   = ($urandom_range(0, 49) != 0);
         clr_all = ($urandom_range(0, 19) == 0);
         req     = 4'($urandom);
         op      = 4'($urandom);
         idx     = 12'($urandom);
         tick();
         checks++; if (gnt8 !== m_gnt[0] || gnt6 !== m_gnt[1]) begin errors++;
            $display("FAIL rand_gnt[%0d] got %b/%b want %b/%b", t, gnt8, gnt6, m_gnt[0], m_gnt[1]); end
         checks++; if (flags8 !== m_flags[0] || flags6 !== m_flags[1][5:0]) begin errors++;
            $display("FAIL rand_flags[%0d] got %h/%h want %h/%h", t, flags8, flags6,
                     m_flags[0], m_flags[1][5:0]); end
         checks++; if (err8 !== m_err[0] || err6 !== m_err[1]) begin errors++;
            $display("FAIL rand_err[%0d] got %b/%b want %b/%b", t, err8, err6, m_err[0], m_err[1]); end
      end
      rst_n = 1'b1; clr_all = 1'b0; req = 4'b0000;
   endtask

   initial begin
      rst_n = 1'b0; clr_all = 1'b0; req = 4'b0000; op = 4'b0000; idx = 12'h000;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_clr_all();
      test_error();
      test_midop_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
